// File: rtl/gth_link_ctrl.sv
// gth_link_ctrl: GTH TMDS serializer bring-up/supervision FSM with per-phase timeouts and retries.
// Optional GTH_UNDERFLOW_RELINK_EN: an underflow edge in RUN also forces a re-link.
module gth_link_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES  = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  gtpowergood,
  input  logic [2:0]  txpmaresetdone,
  input  logic [2:0]  txprgdivresetdone,
  input  logic        tx_done,
  input  logic        locked,
  input  logic        underflow,
  output logic        gt_resetn,
  output logic        video_en,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  state,
  output logic [3:0]  retry_cnt,
  output logic [15:0] underflow_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_ASSERT_RST, S_WAIT_PWR, S_WAIT_DONE, S_SETTLE, S_RUN, S_FAULT
  } state_t;
  localparam int MAXA = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAXC = MAXA > TIMEOUT_CYCLES ? MAXA : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] retry_q, retry_d, retry_inc;
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [11:0] s;
  logic uf_q, good, done, ok, uf_edge, timeout;
  // Synchronizer is not reset: it only ever mirrors the asynchronous inputs.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0],
               {underflow, locked, tx_done, txprgdivresetdone, txpmaresetdone, gtpowergood}};
    uf_q <= s[11];
  end
  assign s = sync_q[SYNC_STAGES-1];
  assign good = (&s[2:0]) & s[10];
  assign done = s[9] & (&s[8:3]);
  assign ok = good & done;
  assign uf_edge = s[11] & ~uf_q;
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign retry_inc = retry_q + 4'd1;
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d = cnt_q + CW'(1);
    case (state_q)
      S_IDLE:       state_d = enable ? S_ASSERT_RST : S_IDLE;
      S_ASSERT_RST: state_d = cnt_q == CW'(RST_CYCLES - 1) ? S_WAIT_PWR : S_ASSERT_RST;
      S_WAIT_PWR, S_WAIT_DONE: begin
        if (state_q == S_WAIT_PWR ? good : ok)
          state_d = state_q == S_WAIT_PWR ? S_WAIT_DONE : S_SETTLE;
        else if (timeout) begin
          retry_d = retry_inc;
          state_d = retry_inc == 4'(MAX_RETRIES) ? S_FAULT : S_ASSERT_RST;
        end
      end
      S_SETTLE: begin
        if (!ok) cnt_d = '0;
        else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
`ifdef GTH_UNDERFLOW_RELINK_EN
        state_d = (!ok || uf_edge) ? S_ASSERT_RST : S_RUN;
`else
        state_d = !ok ? S_ASSERT_RST : S_RUN;
`endif
      end
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      retry_d = '0;
    end
    if (state_d != state_q) cnt_d = '0;
  end
  assign uf_cnt_d = (state_q == S_RUN && uf_edge && uf_cnt_q != 16'hFFFF) ? uf_cnt_q + 16'd1 : uf_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      uf_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      uf_cnt_q <= uf_cnt_d;
    end
  end
  assign state = state_q;
  assign gt_resetn = state_q inside {S_WAIT_PWR, S_WAIT_DONE, S_SETTLE, S_RUN};
  assign video_en = state_q == S_RUN;
  assign link_up = state_q == S_RUN;
  assign fault = state_q == S_FAULT;
  assign retry_cnt = retry_q;
  assign underflow_cnt = uf_cnt_q;
endmodule

// File: tb/tb_gth_link_ctrl.sv
// tb_gth_link_ctrl: directed bench for gth_link_ctrl with small timing parameters.
module tb_gth_link_ctrl;
  logic clk = 0, reset = 1, enable = 0, tx_done = 1, locked = 1, underflow = 0;
  logic [2:0] gtpowergood = 3'b111, txpmaresetdone = 3'b111, txprgdivresetdone = 3'b111;
  logic gt_resetn, video_en, link_up, fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [15:0] underflow_cnt;
  int n_assert = 0, n_fail = 0;

  gth_link_ctrl #(.RST_CYCLES(4), .TIMEOUT_CYCLES(20), .SETTLE_CYCLES(8),
                  .MAX_RETRIES(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gtpowergood(gtpowergood),
    .txpmaresetdone(txpmaresetdone), .txprgdivresetdone(txprgdivresetdone),
    .tx_done(tx_done), .locked(locked), .underflow(underflow),
    .gt_resetn(gt_resetn), .video_en(video_en), .link_up(link_up), .fault(fault),
    .state(state), .retry_cnt(retry_cnt), .underflow_cnt(underflow_cnt));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, input string tag);
    int n = 0;
    while (state !== s && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_gtrst"}, 32'(gt_resetn), 0);
    check({tag, "_video"}, 32'(video_en), 0);
    check({tag, "_link"}, 32'(link_up), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_retry"}, 32'(retry_cnt), 0);
    check({tag, "_ufcnt"}, 32'(underflow_cnt), 0);
  endtask

  initial begin
    tick(3);
    check_reset_vals("rst");
    reset = 0;
    enable = 1;
    tick(1);
    check("up_assert", 32'(state), 1);
    tick(3);
    check("up_rst_hold", 32'(state), 1);
    check("up_gtrst_low", 32'(gt_resetn), 0);
    tick(1);
    check("up_wpwr", 32'(state), 2);
    check("up_gtrst_high", 32'(gt_resetn), 1);
    tick(1);
    check("up_wdone", 32'(state), 3);
    tick(1);
    check("up_settle", 32'(state), 4);
    tick(7);
    check("up_settle7", 32'(state), 4);
    check("up_video_lo", 32'(video_en), 0);
    tick(1);
    check("up_run", 32'(state), 5);
    check("up_link", 32'(link_up), 1);
    check("up_video", 32'(video_en), 1);

    for (int i = 1; i <= 5; i++) begin
      underflow = 1;
      tick(1);
      underflow = 0;
      tick(2);
      check("uf_cnt", 32'(underflow_cnt), 32'(i));
`ifdef GTH_UNDERFLOW_RELINK_EN
      check("uf_relink", 32'(state), 1);
      wait_state(3'd5, 40, "uf_rerun");
`else
      check("uf_stay", 32'(state), 5);
`endif
    end

    gtpowergood = 3'b101;
    tick(2);
    check("pwr_still_run", 32'(state), 5);
    tick(1);
    check("pwr_relink", 32'(state), 1);
    check("pwr_video", 32'(video_en), 0);
    check("pwr_retry", 32'(retry_cnt), 0);
    gtpowergood = 3'b111;
    wait_state(3'd5, 40, "pwr_rerun");
    check("pwr_retry2", 32'(retry_cnt), 0);

    enable = 0;
    tick(1);
    check("dis_idle", 32'(state), 0);
    check("dis_gtrst", 32'(gt_resetn), 0);
    check("dis_video", 32'(video_en), 0);
    enable = 1;
    tick(1);
    check("st_assert", 32'(state), 1);
    tick(4);
    check("st_wpwr", 32'(state), 2);
    tick(1);
    check("st_wdone", 32'(state), 3);
    tick(1);
    check("st_settle", 32'(state), 4);
    tick(3);
    tx_done = 0;
    tick(1);
    tx_done = 1;
    tick(9);
    check("st_restart", 32'(state), 4);
    tick(1);
    check("st_run", 32'(state), 5);

    enable = 0;
    tick(1);
    locked = 0;
    tick(3);
    enable = 1;
    tick(1);
    check("to_assert", 32'(state), 1);
    tick(4);
    check("to_wpwr", 32'(state), 2);
    tick(19);
    check("to_wpwr19", 32'(state), 2);
    check("to_retry0", 32'(retry_cnt), 0);
    tick(1);
    check("to_retry1_st", 32'(state), 1);
    check("to_retry1", 32'(retry_cnt), 1);
    check("to_gtrst", 32'(gt_resetn), 0);
    tick(3);
    check("to_rst2_hold", 32'(state), 1);
    tick(1);
    check("to_wpwr2", 32'(state), 2);
    tick(20);
    check("to_retry2_st", 32'(state), 1);
    check("to_retry2", 32'(retry_cnt), 2);
    tick(24);
    check("to_fault_st", 32'(state), 6);
    check("to_fault", 32'(fault), 1);
    check("to_retry3", 32'(retry_cnt), 3);
    check("to_fault_gtrst", 32'(gt_resetn), 0);
    locked = 1;
    tick(5);
    check("to_sticky", 32'(state), 6);
    enable = 0;
    tick(1);
    check("to_clr_st", 32'(state), 0);
    check("to_clr_retry", 32'(retry_cnt), 0);
    check("to_clr_fault", 32'(fault), 0);

    tx_done = 0;
    enable = 1;
    tick(1);
    check("mr_assert", 32'(state), 1);
    tick(4);
    check("mr_wpwr", 32'(state), 2);
    tick(1);
    check("mr_wdone", 32'(state), 3);
    tick(3);
    check("mr_wdone_hold", 32'(state), 3);
    reset = 1;
    tick(1);
    check_reset_vals("mr");
    reset = 0;
    tick(1);
    check("mr_assert2", 32'(state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
